// File: rtl/t07_button_pkg.sv
// Shared button codes, strobe FSM states and code helpers for the team_07 input
// stage and the game FSMs that consume its one-hot button/strobe pair.
package t07_button_pkg;

  localparam logic [5:0] NO_PRESS = 6'b000000;
  localparam logic [5:0] SELECT   = 6'b000001;
  localparam logic [5:0] UP       = 6'b000010;
  localparam logic [5:0] RIGHT    = 6'b000100;
  localparam logic [5:0] DOWN     = 6'b001000;
  localparam logic [5:0] LEFT     = 6'b010000;
  localparam logic [5:0] BACK     = 6'b100000;

  localparam logic [5:0] DIR_MASK = UP | RIGHT | DOWN | LEFT;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } strobe_state_t;

  function automatic logic is_one_hot(input logic [5:0] v);
    return (v != 6'b000000) && ((v & (v - 6'd1)) == 6'b000000);
  endfunction

  // Only the four cursor directions auto-repeat; SELECT and BACK never do.
  function automatic logic is_direction(input logic [5:0] v);
    return (v & DIR_MASK) != 6'b000000;
  endfunction

endpackage

// File: rtl/t07_sync_debounce.sv
// Two-flop synchroniser plus stable-run counter for the six raw push-buttons;
// deb only follows the synchronised vector once it has held still long enough.
module t07_sync_debounce #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] pb_raw,
  output logic [5:0] deb
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [5:0]       s1;
  logic [5:0]       s2;
  logic [5:0]       s2_prev;
  logic [CNT_W-1:0] stable_cnt;

  // synchronise, count the stable run of s2 and accept it into deb
  always_ff @(posedge clk) begin
    if (rst) begin
      s1         <= 6'b000000;
      s2         <= 6'b000000;
      s2_prev    <= 6'b000000;
      stable_cnt <= '0;
      deb        <= 6'b000000;
    end else begin
      s1      <= pb_raw;
      s2      <= s1;
      s2_prev <= s2;
      if (s2 != s2_prev) begin
        stable_cnt <= '0;
      end else if (stable_cnt != CNT_MAX) begin
        stable_cnt <= stable_cnt + CNT_W'(1);
      end
      // Loading exactly once per stable run keeps deb glitch-free.
      if ((s2 == s2_prev) && (stable_cnt == CNT_LOAD)) begin
        deb <= s2;
      end
    end
  end

endmodule

// File: rtl/t07_button_strobe_gen.sv
// Button front end: debounced vector -> one-hot code, then one strobe per press
// plus timed auto-repeat strobes while a direction stays held.
module t07_button_strobe_gen #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int REPEAT_DELAY    = 5000000,
  parameter int REPEAT_PERIOD   = 1500000,
  parameter int CNT_W           = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] pb_raw,
  output logic [5:0] button,
  output logic       strobe
);

  import t07_button_pkg::*;

  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [5:0]       deb;
  logic [5:0]       code;
  strobe_state_t    state;
  logic [CNT_W-1:0] rpt_cnt;

  t07_sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_sync_debounce (
    .clk   (clk),
    .rst   (rst),
    .pb_raw(pb_raw),
    .deb   (deb)
  );

  // multi-press and no-press both encode to NO_PRESS
  always_comb begin
    if (is_one_hot(deb)) begin
      code = deb;
    end else begin
      code = NO_PRESS;
    end
  end

  // strobe FSM; button holds last cycle's code, so it doubles as the held code
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rpt_cnt <= '0;
      button  <= NO_PRESS;
      strobe  <= 1'b0;
    end else begin
      button <= code;
      strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (code != NO_PRESS) begin
            strobe  <= 1'b1;
            rpt_cnt <= '0;
            state   <= HELD;
          end
        end
        HELD, REPEAT: begin
          if (code == NO_PRESS) begin
            rpt_cnt <= '0;
            state   <= IDLE;
          end else if (code != button) begin
            strobe  <= 1'b1;
            rpt_cnt <= '0;
            state   <= HELD;
          end else if (is_direction(code)) begin
            if (((state == HELD) && (rpt_cnt == DELAY_LAST)) ||
                ((state == REPEAT) && (rpt_cnt == PERIOD_LAST))) begin
              strobe  <= 1'b1;
              rpt_cnt <= '0;
              state   <= REPEAT;
            end else begin
              rpt_cnt <= rpt_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          rpt_cnt <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_t07_button_strobe_gen.sv
// Self-checking bench: window/run-length reference model compared every cycle,
// directed test-plan scenarios with literal strobe timings, then random presses.
module tb_t07_button_strobe_gen;

  localparam int DEB  = 4;
  localparam int RDLY = 10;
  localparam int RPER = 3;
  localparam int CW   = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] pb_raw;
  logic [5:0] button;
  logic       strobe;

  t07_button_strobe_gen #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RDLY),
    .REPEAT_PERIOD  (RPER),
    .CNT_W          (CW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .pb_raw(pb_raw),
    .button(button),
    .strobe(strobe)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // hist[0] is the raw sample of the previous edge; the sync chain makes the
  // vector seen by the debouncer two samples old, and it must have held for
  // DEB+1 consecutive samples before deb follows it.
  logic [5:0] hist [0:DEB+1];
  logic [5:0] m_deb;
  logic [5:0] exp_button;
  logic       exp_strobe;
  int         run_len;
  int         cyc = 0;

  function automatic logic [5:0] encode(input logic [5:0] v);
    return ($countones(v) == 1) ? v : 6'b000000;
  endfunction

  function automatic bit is_dir(input logic [5:0] v);
    return (v == 6'b000010) || (v == 6'b000100) || (v == 6'b001000) || (v == 6'b010000);
  endfunction

  function automatic int next_run(input logic [5:0] c, input logic [5:0] prev, input int run);
    if (c == 6'b000000) return 0;
    if (c != prev) return 1;
    return run + 1;
  endfunction

  // strobe on the first cycle of a code, then for directions after RDLY held
  // cycles and every RPER cycles after that
  function automatic bit strobe_due(input logic [5:0] c, input int run);
    if (c == 6'b000000) return 1'b0;
    if (run == 1) return 1'b1;
    return is_dir(c) && (run - 1 >= RDLY) && (((run - 1 - RDLY) % RPER) == 0);
  endfunction

  function bit window_steady();
    for (int i = 2; i <= DEB + 1; i++) begin
      if (hist[i] != hist[1]) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      for (int i = 0; i <= DEB + 1; i++) hist[i] <= 6'b000000;
      m_deb      <= 6'b000000;
      exp_button <= 6'b000000;
      exp_strobe <= 1'b0;
      run_len    <= 0;
    end else begin
      if (window_steady()) m_deb <= hist[1];
      hist[0] <= pb_raw;
      for (int i = 1; i <= DEB + 1; i++) hist[i] <= hist[i-1];
      exp_button <= encode(m_deb);
      exp_strobe <= strobe_due(encode(m_deb), next_run(encode(m_deb), exp_button, run_len));
      run_len    <= next_run(encode(m_deb), exp_button, run_len);
    end
  end

  // ---------------- stimulus and checking ----------------
  int         vectors = 0;
  int         miscompares = 0;
  int         strobe_cyc [$];
  logic [5:0] strobe_btn [$];
  logic [5:0] btn_log [int];

  task automatic tick(input logic [5:0] raw, input logic r);
    pb_raw = raw;
    rst    = r;
    @(negedge clk);
    vectors++;
    if ((button !== exp_button) || (strobe !== exp_strobe)) begin
      miscompares++;
      $display("FAIL model_cmp cycle %0d: button=%b strobe=%b, required button=%b strobe=%b",
               cyc, button, strobe, exp_button, exp_strobe);
    end
    btn_log[cyc] = button;
    if (strobe === 1'b1) begin
      strobe_cyc.push_back(cyc);
      strobe_btn.push_back(button);
    end
  endtask

  task automatic hold(input logic [5:0] raw, input int n);
    repeat (n) tick(raw, 1'b0);
  endtask

  task automatic check_int(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic clear_log();
    strobe_cyc.delete();
    strobe_btn.delete();
  endtask

  // exactly one strobe, at offset off from t_ref, carrying code btn
  task automatic check_single(input string name, input int t_ref, input int off, input int btn);
    check_int({name, "_count"}, strobe_cyc.size(), 1);
    if (strobe_cyc.size() >= 1) begin
      check_int({name, "_offset"}, strobe_cyc[0] - t_ref, off);
      check_int({name, "_button"}, int'(strobe_btn[0]), btn);
    end
  endtask

  initial begin
    int t0;
    int t1;
    int exp_offs [$];
    int got_offs [$];
    int left_offs [$];
    logic [5:0] seen;

    pb_raw = 6'b000000;
    rst    = 1'b1;
    repeat (3) tick(6'b000000, 1'b1);
    check_int("reset_button", int'(button), 0);
    check_int("reset_strobe", int'(strobe), 0);
    hold(6'b000000, 10);

    // UP held 8 cycles: one strobe at +7, button clears 7 after release
    clear_log();
    t0 = cyc + 1;
    hold(6'b000010, 8);
    t1 = cyc + 1;
    hold(6'b000000, 12);
    check_single("up_press", t0, 7, 2);
    check_int("up_release_before", int'(btn_log[t1 + 6]), 2);
    check_int("up_release_after", int'(btn_log[t1 + 7]), 0);

    // SELECT glitch of 3 cycles: nothing
    clear_log();
    t0 = cyc + 1;
    hold(6'b000001, 3);
    hold(6'b000000, 12);
    check_int("glitch_strobes", strobe_cyc.size(), 0);
    seen = 6'b000000;
    for (int i = t0; i < t0 + 15; i++) seen = seen | btn_log[i];
    check_int("glitch_button", int'(seen), 0);

    // RIGHT held 40: initial strobe, delayed repeat, then periodic repeats
    clear_log();
    t0 = cyc + 1;
    hold(6'b000100, 40);
    hold(6'b000000, 12);
    exp_offs = '{7, 17, 20, 23, 26, 29, 32, 35, 38};
    got_offs.delete();
    foreach (strobe_cyc[i]) if (strobe_cyc[i] - t0 <= 40) got_offs.push_back(strobe_cyc[i] - t0);
    check_int("right_repeat_count", got_offs.size(), exp_offs.size());
    foreach (exp_offs[i]) if (i < got_offs.size()) check_int("right_repeat_offset", got_offs[i], exp_offs[i]);

    // SELECT held 40: never repeats
    clear_log();
    t0 = cyc + 1;
    hold(6'b000001, 40);
    hold(6'b000000, 12);
    check_single("select_hold", t0, 7, 1);

    // UP+LEFT is no press; releasing LEFT yields an UP strobe
    clear_log();
    hold(6'b010010, 10);
    t1 = cyc + 1;
    hold(6'b000010, 8);
    hold(6'b000000, 12);
    check_single("multi_release", t1, 7, 2);

    // DOWN switched straight to LEFT: new strobe at +7, repeat restarts from it
    clear_log();
    t0 = cyc + 1;
    hold(6'b001000, 15);
    t1 = cyc + 1;
    hold(6'b010000, 20);
    hold(6'b000000, 12);
    left_offs.delete();
    foreach (strobe_cyc[i]) if (strobe_btn[i] == 6'b010000) left_offs.push_back(strobe_cyc[i] - t1);
    check_int("switch_left_count_min", int'(left_offs.size() >= 2), 1);
    if (left_offs.size() >= 2) begin
      check_int("switch_left_first", left_offs[0], 7);
      check_int("switch_left_repeat", left_offs[1] - left_offs[0], 10);
    end

    // BACK held, 1-cycle reset: outputs clear at once, one fresh strobe follows
    hold(6'b100000, 20);
    tick(6'b100000, 1'b1);
    check_int("midhold_reset_button", int'(button), 0);
    check_int("midhold_reset_strobe", int'(strobe), 0);
    clear_log();
    t1 = cyc + 1;
    hold(6'b100000, 20);
    hold(6'b000000, 12);
    check_single("after_reset", t1, 7, 32);

    // randomized presses, bounces, multi-presses and occasional resets
    for (int seg = 0; seg < 160; seg++) begin
      int kind;
      int len;
      logic [5:0] v;
      kind = $urandom_range(0, 99);
      if (kind < 60) v = 6'b000001 << $urandom_range(0, 5);
      else if (kind < 75) v = 6'b000000;
      else v = 6'($urandom);
      if (kind >= 90) len = $urandom_range(1, DEB);
      else len = $urandom_range(1, 45);
      if ($urandom_range(0, 29) == 0) tick(v, 1'b1);
      hold(v, len);
    end
    hold(6'b000000, 15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
